// File: rtl/send_word_as_ascii.sv
// Prints a captured N-bit word on the UART TX buffer as binary or hex ASCII, MSB first, ending in CR LF.
// Define SEND_ASCII_PREFIX_EN to precede the digits with "0b" / "0x".
module send_word_as_ascii #(
    parameter int N     = 48,
    parameter int GROUP = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] data_in,
    input  logic         mode,
    input  logic         tx_full,
    output logic [7:0]   tx_data,
    output logic         tx_write,
    output logic         busy,
    output logic         done
);

    localparam int DH = (N + 3) / 4;
    localparam int W  = 4 * DH;
    localparam int CW = $clog2(N + 1);
    localparam int GW = $clog2(GROUP + 2);

    localparam logic [CW-1:0] D_BIN  = CW'(N);
    localparam logic [CW-1:0] D_HEX  = CW'(DH);
    localparam logic [GW-1:0] G_LAST = GW'((GROUP > 0) ? GROUP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef SEND_ASCII_PREFIX_EN
        S_PREFIX0,
        S_PREFIX1,
`endif
        S_DIGIT,
        S_SEP,
        S_CR,
        S_LF
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_shift;
    logic            r_mode;
    logic [CW-1:0]   r_d;
    logic [CW-1:0]   r_k;
    logic [GW-1:0]   r_g;
    logic            r_done;

    logic [3:0]      w_nib;
    logic [7:0]      w_hex;
    logic [CW-1:0]   w_k_next;

    assign w_nib    = r_shift[W-1 -: 4];
    assign w_hex    = (w_nib < 4'd10) ? (8'd48 + {4'd0, w_nib}) : (8'd55 + {4'd0, w_nib});
    assign w_k_next = r_k + CW'(1);

    // Reset gates the strobe so nothing is accepted in the cycle the transfer is aborted.
    assign tx_write = rst_n && (r_state != S_IDLE) && !tx_full;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;

    always_comb begin
        tx_data = 8'd0;
        case (r_state)
`ifdef SEND_ASCII_PREFIX_EN
            S_PREFIX0: tx_data = 8'd48;
            S_PREFIX1: tx_data = r_mode ? 8'd120 : 8'd98;
`endif
            S_DIGIT:   tx_data = r_mode ? w_hex : (r_shift[W-1] ? 8'd49 : 8'd48);
            S_SEP:     tx_data = 8'd32;
            S_CR:      tx_data = 8'd13;
            S_LF:      tx_data = 8'd10;
            default:   tx_data = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_mode  <= 1'b0;
            r_d     <= '0;
            r_k     <= '0;
            r_g     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    // Binary is left-aligned; hex is zero-extended into the padded nibble grid.
                    r_shift <= mode ? W'(data_in) : (W'(data_in) << (W - N));
                    r_mode  <= mode;
                    r_d     <= mode ? D_HEX : D_BIN;
                    r_k     <= '0;
                    r_g     <= '0;
`ifdef SEND_ASCII_PREFIX_EN
                    r_state <= S_PREFIX0;
`else
                    r_state <= S_DIGIT;
`endif
                end
            end else if (tx_write) begin
                case (r_state)
`ifdef SEND_ASCII_PREFIX_EN
                    S_PREFIX0: r_state <= S_PREFIX1;
                    S_PREFIX1: r_state <= S_DIGIT;
`endif
                    S_DIGIT: begin
                        r_shift <= r_mode ? (r_shift << 4) : (r_shift << 1);
                        r_k     <= w_k_next;
                        if (w_k_next == r_d) begin
                            r_state <= S_CR;
                        end else if ((GROUP != 0) && (r_g == G_LAST)) begin
                            r_g     <= '0;
                            r_state <= S_SEP;
                        end else begin
                            r_g <= r_g + GW'(1);
                        end
                    end
                    S_SEP: r_state <= S_DIGIT;
                    S_CR:  r_state <= S_LF;
                    S_LF: begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_send_word_as_ascii.sv
// Bench for send_word_as_ascii: directed and random lines compared against a character-list model.
module tb_send_word_as_ascii;

    localparam int N     = 10;
    localparam int GROUP = 3;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         start   = 1'b0;
    logic         mode    = 1'b0;
    logic         tx_full = 1'b0;
    logic [N-1:0] data_in = '0;
    logic [7:0]   tx_data;
    logic         tx_write;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    send_word_as_ascii #(.N(N), .GROUP(GROUP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .mode     (mode),
        .tx_full  (tx_full),
        .tx_data  (tx_data),
        .tx_write (tx_write),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Expected line: digits MSB first, a space after every GROUP digits except after the last, then CR LF.
    function automatic void build(input logic [N-1:0] d, input logic m);
        int dcnt;
        int v;
        dcnt = m ? (N + 3) / 4 : N;
        exp_q.delete();
`ifdef SEND_ASCII_PREFIX_EN
        exp_q.push_back(48);
        exp_q.push_back(m ? 120 : 98);
`endif
        for (int i = 0; i < dcnt; i++) begin
            if (m) begin
                v = (int'(d) >> (4 * (dcnt - 1 - i))) & 15;
                exp_q.push_back(v < 10 ? 48 + v : 65 + v - 10);
            end else begin
                v = (int'(d) >> (N - 1 - i)) & 1;
                exp_q.push_back(v ? 49 : 48);
            end
            if (GROUP != 0 && (i + 1) < dcnt && ((i + 1) % GROUP) == 0)
                exp_q.push_back(32);
        end
        exp_q.push_back(13);
        exp_q.push_back(10);
    endfunction

    task automatic start_line(input logic [N-1:0] d, input logic m);
        build(d, m);
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        mode    = m;
        tx_full = 1'b0;
        #1;
        chk("idle_wr", tx_write, 0);
        chk("idle_busy", busy, 0);
        @(negedge clk);
        start   = 1'b0;
        data_in = ~d;
    endtask

    // stall: 0 none, 1 random, 2 three cycles after the second character
    task automatic run_body(input int limit, input int stall, input bit restart, input logic [N-1:0] alt);
        int idx = 0;
        int cyc = 0;
        int hold = 0;
        bit restarted = 1'b0;
        while (idx < limit && cyc < 300) begin
            start = 1'b0;
            if (restart && !restarted && idx == 3) begin
                start     = 1'b1;
                data_in   = alt;
                mode      = ~mode;
                restarted = 1'b1;
            end
            case (stall)
                1: tx_full = ($urandom_range(0, 2) == 0);
                2: begin
                    if (idx == 2 && hold < 3) begin
                        tx_full = 1'b1;
                        hold++;
                    end else begin
                        tx_full = 1'b0;
                    end
                end
                default: tx_full = 1'b0;
            endcase
            #1;
            chk("busy", busy, 1);
            chk("done_low", done, 0);
            if (tx_full) begin
                chk("stall_wr", tx_write, 0);
                chk("stall_data", tx_data, exp_q[idx]);
            end else begin
                chk("wr", tx_write, 1);
                chk("char", tx_data, exp_q[idx]);
                idx++;
            end
            cyc++;
            if (idx < limit) @(negedge clk);
        end
        if (idx < limit) chk("timeout", idx, limit);
        tx_full = 1'b0;
        start   = 1'b0;
    endtask

    task automatic finish_line(input bit chain, input logic [N-1:0] d, input logic m);
        @(negedge clk);
        tx_full = 1'b0;
        start   = chain;
        if (chain) begin
            data_in = d;
            mode    = m;
        end
        #1;
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("wr_end", tx_write, 0);
        @(negedge clk);
        start = 1'b0;
        if (!chain) begin
            #1;
            chk("done_once", done, 0);
        end
    endtask

    task automatic line(input logic [N-1:0] d, input logic m, input int stall);
        start_line(d, m);
        run_body(exp_q.size(), stall, 1'b0, '0);
        finish_line(1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [31:0] r;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_data", tx_data, 0);
        chk("rst_wr", tx_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;

        line(10'h2A5, 1'b0, 0);
        line(10'h2AF, 1'b1, 0);
        line(10'h005, 1'b1, 0);
        line(10'h3FF, 1'b1, 0);
        line(10'h001, 1'b0, 2);

        start_line(10'h155, 1'b0);
        run_body(exp_q.size(), 0, 1'b1, 10'h2AA);
        finish_line(1'b0, '0, 1'b0);

        // start coincident with done begins the next line immediately
        start_line(10'h0F0, 1'b0);
        run_body(exp_q.size(), 0, 1'b0, '0);
        build(10'h1C3, 1'b1);
        finish_line(1'b1, 10'h1C3, 1'b1);
        run_body(exp_q.size(), 0, 1'b0, '0);
        finish_line(1'b0, '0, 1'b0);

        start_line(10'h3A7, 1'b0);
        run_body(3, 0, 1'b0, '0);
        @(negedge clk);
        rst_n   = 1'b0;
        start   = 1'b1;
        data_in = 10'h111;
        #1;
        chk("abort_wr", tx_write, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_wr2", tx_write, 0);
        chk("abort_data", tx_data, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        #1;
        chk("abort_idle", busy, 0);
        line(10'h2C9, 1'b1, 0);

        for (int t = 0; t < 8; t++) begin
            r = $urandom;
            line(r[N-1:0], r[N], 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/send_word_as_ascii.md
Name: send_word_as_ascii

Overview:
- Parametrised successor to the single-mode binary dump serializer.
- On a start pulse, captures an N-bit word and emits it as ASCII characters to the UART transmit buffer, one character per accepted cycle. Output is binary or hexadecimal digits, MSB first, with optional space grouping, terminated by CR LF.
- Honours UART buffer back-pressure.
- Sits between datapath debug taps (perceptron weights/outputs) and the UART TX macro.

Parameters:
N, 48, width of captured word (>=1)
GROUP, 8, digits per space-separated group; 0 = no separators

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request; captures data_in and mode when idle
data_in  in  N  word to print
mode  in  1  0 = binary digits, 1 = hex digits
tx_full  in  1  UART TX buffer full; stalls emission
tx_data  out  8  ASCII character
tx_write  out  1  write strobe into UART TX buffer
busy  out  1  high from capture cycle+1 until after LF written
done  out  1  one-cycle pulse the cycle after LF accepted

Behaviour:
- Reset: synchronous on posedge clk when rst_n=0. State=IDLE; busy=0, done=0, tx_write=0, tx_data=8'd0; shift register and counters cleared.
- Capture: in IDLE with start=1, latch data_in, mode, and the digit count D. D=N for binary; D=ceil(N/4) for hex, with the word zero-extended at the MSB end to 4*D bits. Enter DIGIT (or PREFIX0 if macro). No character is emitted in the capture cycle.
- start while busy: ignored, no effect on the transfer in progress.
- tx_write = (state != IDLE) && !tx_full, combinational. tx_data is combinational from state and shift register; tx_data=0 in IDLE.
- Character accepted = tx_write high at posedge. State and counters advance only on acceptance. tx_full=1 holds everything and keeps tx_data stable.
- DIGIT:
  - Binary: char = msb ? 49 : 48; shift left 1.
  - Hex: nibble 0-9 -> 48+n, 10-15 -> 65+(n-10) (uppercase); shift left 4.
  - Increment digit index k (1-based after emission).
  - If k==D -> CR. Else if GROUP!=0 and k%GROUP==0 -> SEP. Else stay in DIGIT.
- SEP: char 32; -> DIGIT. Never emitted after the last digit.
- CR: char 13; -> LF.
- LF: char 10; -> IDLE; done=1 next cycle.
- busy=1 in every non-IDLE state.
- Total characters = D + (GROUP ? floor((D-1)/GROUP) : 0) + 2 (+2 with prefix).
- With tx_full=0 throughout: the first char is written the cycle after capture, and busy deasserts the cycle after LF.
- done and start in the same cycle: start is accepted, since the state is already IDLE.
- Reset mid-transfer: tx_write drops in the reset cycle; no partial CR/LF is emitted; start in the reset cycle is ignored.
- Counters sized $clog2(N+1); the hex shift uses the 4*D-bit padded register.

Optional Feature:
- Macro: SEND_ASCII_PREFIX_EN.
- When defined: states PREFIX0/PREFIX1 precede DIGIT and emit '0' (48) then 'b' (98) for binary or 'x' (120) for hex, under the same stall rules.
- When undefined: those states do not exist and the first character is the first digit.

Test Plan:
- N=8, GROUP=4, mode=0, data_in=8'hA5, tx_full=0 -> tx_data sequence 49,48,49,48,32,48,49,48,49,13,10 on 11 consecutive cycles; done pulses once the following cycle.
- N=10, GROUP=0, mode=1, data_in=10'h2AF -> 50,65,70,13,10 ("2AF\r\n"); then data_in=10'h005 -> 48,48,53,13,10.
- N=8, mode=0, data_in=8'h01, tx_full high for 3 cycles after the 2nd char -> tx_write low and tx_data held at 48 for those cycles; full sequence 48x7,49,13,10 with no loss or duplication.
- start re-pulsed with a different data_in mid-transfer -> output unchanged, busy continuous, exactly one done.
- rst_n=0 after the 3rd char -> next cycle tx_write=0, busy=0, tx_data=0; a fresh start afterwards prints a complete line.
- SEND_ASCII_PREFIX_EN defined, N=4, mode=1, data_in=4'hC -> 48,120,67,13,10.
